// File: rtl/timer_pkg.sv
// Shared types, constants and helpers for the BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } tmr_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned BCD_W    = 4;
  localparam bcd_digit_t  BCD_MAX  = 4'd9;
  localparam bcd_digit_t  BCD_ZERO = 4'd0;

  // Clamp a non-decimal nibble to 9 so the counter never holds an invalid digit.
  function automatic bcd_digit_t bcd_sat(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down-counter: load, decrement with 0->9 wrap, borrow out.
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  bcd_digit_t i_load_d,
  input  logic       i_dec_en,
  output bcd_digit_t o_d,
  output logic       o_borrow
);

  bcd_digit_t r_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d <= BCD_ZERO;
    end else if (i_load) begin
      r_d <= i_load_d;
    end else if (i_dec_en) begin
      r_d <= (r_d == BCD_ZERO) ? BCD_MAX : bcd_digit_t'(r_d - 4'd1);
    end
  end

  assign o_d      = r_d;
  assign o_borrow = i_dec_en && (r_d == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with load/start/pause and a terminal-count pulse.
// Build option AUTO_RELOAD_EN: expiry reloads the last loaded value and keeps running.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  input  logic                tick,
  output logic [4*DIGITS-1:0] q,
  output logic                running,
  output logic                done,
  output logic                expired
);

  localparam int unsigned W = BCD_W * DIGITS;

  tmr_state_t   r_state;
  tmr_state_t   w_state_nxt;
  logic         r_running;
  logic         r_expired;
  logic         r_done;

  logic         w_ld;
  logic         w_ld_reload;
  logic         w_ld_any;
  logic         w_dec;
  logic         w_done_nxt;
  logic         w_upper_zero;
  logic         w_zero;
  logic         w_last;
  logic         w_reload_zero;
  logic [W-1:0] w_load_san;
  logic [W-1:0] w_ld_data;
  logic [DIGITS:0] w_borrow;
  logic         w_unused_top_borrow;
  bcd_digit_t   w_digit [DIGITS];

  // Digit chain: each digit's borrow drives the next digit's decrement.
  assign w_borrow[0] = w_dec;
  assign w_ld_any    = w_ld | w_ld_reload;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign w_load_san[BCD_W*g +: BCD_W] = bcd_sat(load_val[BCD_W*g +: BCD_W]);

    bcd_digit_down u_digit (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_ld_any),
      .i_load_d (w_ld_data[BCD_W*g +: BCD_W]),
      .i_dec_en (w_borrow[g]),
      .o_d      (w_digit[g]),
      .o_borrow (w_borrow[g+1])
    );

    assign q[BCD_W*g +: BCD_W] = w_digit[g];
  end

  // Decrements are never issued at zero, so the top borrow cannot fire.
  assign w_unused_top_borrow = w_borrow[DIGITS];

  always_comb begin
    w_upper_zero = 1'b1;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if (w_digit[i] != BCD_ZERO) w_upper_zero = 1'b0;
    end
  end

  assign w_zero = w_upper_zero && (w_digit[0] == BCD_ZERO);
  assign w_last = w_upper_zero && (w_digit[0] <= 4'd1);

`ifdef AUTO_RELOAD_EN
  logic [W-1:0] r_reload;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reload <= '0;
    end else if (w_ld) begin
      r_reload <= w_load_san;
    end
  end

  assign w_reload_zero = (r_reload == '0);
  assign w_ld_data     = w_ld_reload ? r_reload : w_load_san;
`else
  assign w_reload_zero = 1'b1;
  assign w_ld_data     = w_load_san;
`endif

  // State and decoded status flags are registered together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == RUN);
      r_expired <= (w_state_nxt == EXPIRED);
      r_done    <= w_done_nxt;
    end
  end

  // Priority inside every state: load > pause > start > tick.
  always_comb begin
    w_state_nxt = r_state;
    w_ld        = 1'b0;
    w_ld_reload = 1'b0;
    w_dec       = 1'b0;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      IDLE, EXPIRED: begin
        if (load) begin
          w_ld        = 1'b1;
          w_state_nxt = IDLE;
        end else if (pause) begin
          w_state_nxt = r_state;
        end else if (start) begin
          if (w_zero) begin
            w_state_nxt = EXPIRED;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
        end
      end

      RUN: begin
        if (load) begin
          w_ld = 1'b1;
        end else if (pause) begin
          w_state_nxt = PAUSE;
        end else if (tick) begin
          if (w_last) begin
            w_done_nxt = 1'b1;
            if (!w_reload_zero) begin
              w_ld_reload = 1'b1;
            end else begin
              w_dec       = !w_zero;
              w_state_nxt = EXPIRED;
            end
          end else begin
            w_dec = 1'b1;
          end
        end
      end

      PAUSE: begin
        if (load) begin
          w_ld = 1'b1;
        end else if (pause) begin
          w_state_nxt = PAUSE;
        end else if (start) begin
          w_state_nxt = RUN;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign running = r_running;
  assign expired = r_expired;
  assign done    = r_done;

endmodule
